csa_accum_sched: RTL and testbench
==================================

CSA_ACCUM_SCHED -- requirements
Module: csa_accum_sched

Interface
REQ-001 SHALL have parameter p_input_width, default 14, width of each unsigned operand.
REQ-002 SHALL have parameter p_beat_w, default 4; the maximum frame length is 2^p_beat_w beats.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_flush  input  1  synchronous abort of the current frame.
REQ-006 SHALL have port i_valid  input  1  operand beat valid.
REQ-007 SHALL have port o_ready  output  1  beat accepted when i_valid & o_ready.
REQ-008 SHALL have port i_ops  input  8*p_input_width  eight packed operands; operand k is at bits [k*p_input_width +: p_input_width].
REQ-009 SHALL have port i_last  input  1  marks the final beat of a frame.
REQ-010 SHALL have port o_valid  output  1  frame result valid.
REQ-011 SHALL have port i_ready  input  1  consumer accepts the result when o_valid & i_ready.
REQ-012 SHALL have port o_sum  output  p_input_width+3+p_beat_w  frame sum.
REQ-013 SHALL have port o_nbeats  output  p_beat_w+1  number of beats in the reported frame.
REQ-014 SHALL have port o_trunc  output  1  the frame was closed at the maximum length without i_last.

Function
REQ-015 SHALL instantiate one csa_adder_8in with p_input_width and reduce the eight operands of each accepted beat combinationally in the same cycle.
REQ-016 SHALL implement states IDLE, ACCUM and DONE.
REQ-017 SHALL drive o_ready=1 in IDLE and ACCUM, and o_ready=i_ready in DONE.
REQ-018 SHALL, on the first accepted beat of a frame, load the accumulator with the zero-extended adder sum and the beat counter with 1.
REQ-019 SHALL, on each later accepted beat, add the zero-extended adder sum to the accumulator and increment the beat counter; all arithmetic is unsigned and cannot overflow at the stated widths.
REQ-020 SHALL move IDLE->ACCUM on an accepted beat with i_last=0, and IDLE/ACCUM->DONE on an accepted beat with i_last=1.
REQ-021 SHALL, on an accepted beat that makes the counter equal 2^p_beat_w with i_last=0, go to DONE and set o_trunc=1; otherwise o_trunc=0.
REQ-022 SHALL assert o_valid exactly while in DONE, with o_sum, o_nbeats and o_trunc held stable until the result handshake; latency is one cycle from the last-beat accept to o_valid=1.
REQ-023 SHALL, in DONE on a result handshake with no beat accepted, go to IDLE.
REQ-024 SHALL, in DONE on a cycle where the result handshake and a beat accept occur together, start a new frame with that beat and go to ACCUM, or stay in DONE for a one-beat frame, so that back-to-back frames carry no bubble.
REQ-025 SHALL, when i_flush=1, go to IDLE, clear the accumulator, counter, o_valid and o_trunc, and ignore i_valid that cycle; flush takes priority over every other event.
REQ-026 SHALL ignore i_ops and i_last whenever no beat is accepted.

Reset
REQ-027 SHALL, while i_rst_n=0, force state IDLE, accumulator 0, counter 0, o_valid=0, o_sum=0, o_nbeats=0, o_trunc=0 and o_ready=1 after release; a reset mid-frame discards the partial sum.

Configuration
REQ-028 SHALL, with macro CSA_ACCUM_THRESHOLD_EN defined, add ports i_threshold (input, same width as o_sum) and o_fire (output, 1); o_fire is registered with the result and equals (o_sum >= i_threshold) sampled at the last-beat accept, is valid only with o_valid, and resets to 0.
REQ-029 SHALL, without CSA_ACCUM_THRESHOLD_EN, have neither port nor the compare logic, with all other behaviour identical.

Verification
REQ-030 SHALL cover a single beat of eight operands of 16383 each with i_last=1 -> next cycle o_valid=1, o_sum=131064, o_nbeats=1, o_trunc=0.
REQ-031 SHALL cover three beats of operands 1..8 with i_last on the third -> o_sum=108, o_nbeats=3; with i_ready held low, the outputs stay stable and o_ready=0.
REQ-032 SHALL cover 16 beats of all-16383 operands with i_last=0 (p_beat_w=4) -> o_sum=2097024, o_nbeats=16, o_trunc=1.
REQ-033 SHALL cover i_ready=1 while streaming one-beat frames every cycle -> one result per cycle, no lost or duplicated frames.
REQ-034 SHALL cover i_flush and, separately, i_rst_n pulsed after 2 of 4 beats, followed by a fresh frame of one beat of 5s -> o_sum=40, o_nbeats=1.
REQ-035 SHALL cover, with CSA_ACCUM_THRESHOLD_EN and i_threshold=108, the frame of REQ-031 -> o_fire=1; with i_threshold=109 -> o_fire=0.

Source files
------------

// File: rtl/csa_accum_sched.sv
// Frame accumulator: each accepted beat of eight operands is reduced by a carry-save tree and summed into a per-frame result.
// Optional threshold compare output is enabled by defining CSA_ACCUM_THRESHOLD_EN.

module csa_adder_8in #(
    parameter int p_input_width = 14
) (
    input  logic [8*p_input_width-1:0] i_ops,
    output logic [p_input_width+2:0]   o_sum
);
    localparam int lp_w = p_input_width + 3;

    // 3:2 compressor; the carry word is pre-shifted, and its dropped MSB is always zero because the true sum fits in lp_w bits
    function automatic logic [2*lp_w-1:0] csa3(input logic [lp_w-1:0] a, input logic [lp_w-1:0] b,
                                               input logic [lp_w-1:0] c);
        logic [lp_w-1:0] maj_v;
        maj_v = (a & b) | (a & c) | (b & c);
        return {maj_v[lp_w-2:0], 1'b0, a ^ b ^ c};
    endfunction

    logic [lp_w-1:0] op_s  [8];
    logic [lp_w-1:0] sum_s [6];
    logic [lp_w-1:0] car_s [6];

    // zero-extend each operand to the tree width
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            op_s[k] = {3'b000, i_ops[k*p_input_width +: p_input_width]};
        end
    end

    assign {car_s[0], sum_s[0]} = csa3(op_s[0], op_s[1], op_s[2]);
    assign {car_s[1], sum_s[1]} = csa3(op_s[3], op_s[4], op_s[5]);
    assign {car_s[2], sum_s[2]} = csa3(sum_s[0], car_s[0], sum_s[1]);
    assign {car_s[3], sum_s[3]} = csa3(car_s[1], op_s[6], op_s[7]);
    assign {car_s[4], sum_s[4]} = csa3(sum_s[2], car_s[2], sum_s[3]);
    assign {car_s[5], sum_s[5]} = csa3(sum_s[4], car_s[4], car_s[3]);
    assign o_sum = sum_s[5] + car_s[5];
endmodule

module csa_accum_sched #(
    parameter int p_input_width = 14,
    parameter int p_beat_w      = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_flush,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic [8*p_input_width-1:0]          i_ops,
    input  logic                                i_last,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic [p_input_width+3+p_beat_w-1:0] o_sum,
    output logic [p_beat_w:0]                   o_nbeats,
    output logic                                o_trunc
`ifdef CSA_ACCUM_THRESHOLD_EN
    ,
    input  logic [p_input_width+3+p_beat_w-1:0] i_threshold,
    output logic                                o_fire
`endif
);
    localparam int lp_add_w = p_input_width + 3;
    localparam int lp_sum_w = p_input_width + 3 + p_beat_w;
    localparam int lp_cnt_w = p_beat_w + 1;
    localparam logic [lp_cnt_w-1:0] lp_max_beats = lp_cnt_w'(1) << p_beat_w;

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_accum = 2'd1,
        st_done  = 2'd2
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [lp_sum_w-1:0]   acc_r, acc_nxt_s;
    logic [lp_cnt_w-1:0]   cnt_r, cnt_nxt_s;
    logic                  trunc_r, trunc_nxt_s;
    logic                  valid_r, valid_nxt_s;
    logic [lp_add_w-1:0]   add_sum_s;
    logic [lp_sum_w-1:0]   add_ext_s;
    logic                  ready_s;
    logic                  accept_s;
    logic                  hs_s;
`ifdef CSA_ACCUM_THRESHOLD_EN
    logic                  fire_r, fire_nxt_s;
`endif

    csa_adder_8in #(.p_input_width(p_input_width)) u_adder (
        .i_ops (i_ops),
        .o_sum (add_sum_s)
    );

    assign add_ext_s = {{p_beat_w{1'b0}}, add_sum_s};
    // a pending result only accepts a new beat in the same cycle it is consumed
    assign ready_s   = (state_r == st_done) ? i_ready : 1'b1;
    assign accept_s  = i_valid & ready_s;
    assign hs_s      = valid_r & i_ready;

    // next-state and datapath update; flush overrides any beat or handshake
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        trunc_nxt_s = trunc_r;
        valid_nxt_s = valid_r;
`ifdef CSA_ACCUM_THRESHOLD_EN
        fire_nxt_s  = fire_r;
`endif
        if (i_flush) begin
            state_nxt_s = st_idle;
            acc_nxt_s   = {lp_sum_w{1'b0}};
            cnt_nxt_s   = {lp_cnt_w{1'b0}};
            trunc_nxt_s = 1'b0;
            valid_nxt_s = 1'b0;
`ifdef CSA_ACCUM_THRESHOLD_EN
            fire_nxt_s  = 1'b0;
`endif
        end else if (accept_s) begin
            case (state_r)
                st_accum: begin
                    acc_nxt_s = acc_r + add_ext_s;
                    cnt_nxt_s = cnt_r + lp_cnt_w'(1);
                end
                default: begin
                    acc_nxt_s = add_ext_s;
                    cnt_nxt_s = lp_cnt_w'(1);
                end
            endcase
            if (i_last || (cnt_nxt_s == lp_max_beats)) begin
                state_nxt_s = st_done;
                valid_nxt_s = 1'b1;
                trunc_nxt_s = ~i_last;
`ifdef CSA_ACCUM_THRESHOLD_EN
                fire_nxt_s  = (acc_nxt_s >= i_threshold);
`endif
            end else begin
                state_nxt_s = st_accum;
                valid_nxt_s = 1'b0;
                trunc_nxt_s = 1'b0;
            end
        end else if (hs_s) begin
            state_nxt_s = st_idle;
            valid_nxt_s = 1'b0;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // state and result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= st_idle;
            acc_r   <= {lp_sum_w{1'b0}};
            cnt_r   <= {lp_cnt_w{1'b0}};
            trunc_r <= 1'b0;
            valid_r <= 1'b0;
`ifdef CSA_ACCUM_THRESHOLD_EN
            fire_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            trunc_r <= trunc_nxt_s;
            valid_r <= valid_nxt_s;
`ifdef CSA_ACCUM_THRESHOLD_EN
            fire_r  <= fire_nxt_s;
`endif
        end
    end

    assign o_ready  = ready_s;
    assign o_valid  = valid_r;
    assign o_sum    = acc_r;
    assign o_nbeats = cnt_r;
    assign o_trunc  = trunc_r;
`ifdef CSA_ACCUM_THRESHOLD_EN
    assign o_fire   = fire_r;
`endif
endmodule

// File: tb/tb_csa_accum_sched.sv
// Randomized and directed bench for csa_accum_sched against a frame-level reference model.
// Define CSA_ACCUM_THRESHOLD_EN to also check the threshold output.

module tb_csa_accum_sched;
    localparam int W  = 14;
    localparam int BW = 4;
    localparam int SW = W + 3 + BW;
    localparam int MAXB = 1 << BW;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_flush;
    logic            i_valid;
    logic            o_ready;
    logic [8*W-1:0]  i_ops;
    logic            i_last;
    logic            o_valid;
    logic            i_ready;
    logic [SW-1:0]   o_sum;
    logic [BW:0]     o_nbeats;
    logic            o_trunc;
    logic [SW-1:0]   thr;
`ifdef CSA_ACCUM_THRESHOLD_EN
    logic            o_fire;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // frame-level model: pending result and the frame being collected
    int m_pend, m_psum, m_pnb, m_ptrunc, m_pfire;
    int m_fsum, m_fcnt;

    csa_accum_sched #(.p_input_width(W), .p_beat_w(BW)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_ops    (i_ops),
        .i_last   (i_last),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sum    (o_sum),
        .o_nbeats (o_nbeats),
        .o_trunc  (o_trunc)
`ifdef CSA_ACCUM_THRESHOLD_EN
        ,
        .i_threshold (thr),
        .o_fire      (o_fire)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [8*W-1:0] ops_fill(input int v);
        logic [8*W-1:0] r;
        for (int k = 0; k < 8; k++) r[k*W +: W] = W'(v);
        return r;
    endfunction

    function automatic logic [8*W-1:0] ops_seq();
        logic [8*W-1:0] r;
        for (int k = 0; k < 8; k++) r[k*W +: W] = W'(k + 1);
        return r;
    endfunction

    function automatic logic [8*W-1:0] ops_rand();
        logic [8*W-1:0] r;
        for (int k = 0; k < 8; k++) r[k*W +: W] = W'($urandom_range(0, (1 << W) - 1));
        return r;
    endfunction

    function automatic int ops_total(input logic [8*W-1:0] ops);
        int s = 0;
        for (int k = 0; k < 8; k++) s += int'(ops[k*W +: W]);
        return s;
    endfunction

    task automatic model_clear();
        m_pend = 0; m_psum = 0; m_pnb = 0; m_ptrunc = 0; m_pfire = 0;
        m_fsum = 0; m_fcnt = 0;
    endtask

    // one clock: drive at negedge, check ready, advance model, check result after the edge
    task automatic cycle(input logic v, input logic [8*W-1:0] ops, input logic last,
                         input logic rdy, input logic flush);
        int exp_rdy;
        int acc;
        i_valid = v; i_ops = ops; i_last = last; i_ready = rdy; i_flush = flush;
        #1;
        exp_rdy = (m_pend == 0 || rdy) ? 1 : 0;
        check_val("ready", 32'(o_ready), 32'(exp_rdy));
        acc = (v && exp_rdy && !flush) ? 1 : 0;
        if (flush) begin
            model_clear();
        end else begin
            if (m_pend != 0 && rdy) m_pend = 0;
            if (acc != 0) begin
                m_fsum += ops_total(ops);
                m_fcnt++;
                if (last || m_fcnt == MAXB) begin
                    m_pend = 1; m_psum = m_fsum; m_pnb = m_fcnt;
                    m_ptrunc = last ? 0 : 1;
                    m_pfire = (m_fsum >= int'(thr)) ? 1 : 0;
                    m_fsum = 0; m_fcnt = 0;
                end
            end
        end
        @(posedge i_clk);
        #1;
        check_val("valid", 32'(o_valid), 32'(m_pend));
        if (m_pend != 0) begin
            check_val("sum", 32'(o_sum), 32'(m_psum));
            check_val("nbeats", 32'(o_nbeats), 32'(m_pnb));
            check_val("trunc", 32'(o_trunc), 32'(m_ptrunc));
`ifdef CSA_ACCUM_THRESHOLD_EN
            check_val("fire", 32'(o_fire), 32'(m_pfire));
`endif
        end
        @(negedge i_clk);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_valid"}, 32'(o_valid), 32'd0);
        check_val({tag, "_sum"}, 32'(o_sum), 32'd0);
        check_val({tag, "_nbeats"}, 32'(o_nbeats), 32'd0);
        check_val({tag, "_trunc"}, 32'(o_trunc), 32'd0);
        check_val({tag, "_ready"}, 32'(o_ready), 32'd1);
`ifdef CSA_ACCUM_THRESHOLD_EN
        check_val({tag, "_fire"}, 32'(o_fire), 32'd0);
`endif
    endtask

    task automatic pulse_reset();
        i_rst_n = 1'b0;
        #2;
        check_reset_state("rst_mid");
        model_clear();
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ops = '0; i_last = 1'b0; i_ready = 1'b0;
        thr = SW'(108);
        model_clear();
        @(negedge i_clk);
        @(negedge i_clk);
        check_reset_state("rst");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // single full-scale beat
        cycle(1'b1, ops_fill(16383), 1'b1, 1'b0, 1'b0);
        check_val("max1_sum", 32'(o_sum), 32'd131064);
        check_val("max1_nbeats", 32'(o_nbeats), 32'd1);
        cycle(1'b0, ops_rand(), 1'b0, 1'b1, 1'b0);

        // three beats with consumer stalled, then released
        for (int t = 0; t < 2; t++) begin
            thr = SW'(108 + t);
            cycle(1'b1, ops_seq(), 1'b0, 1'b0, 1'b0);
            cycle(1'b1, ops_seq(), 1'b0, 1'b0, 1'b0);
            cycle(1'b1, ops_seq(), 1'b1, 1'b0, 1'b0);
            check_val("seq3_sum", 32'(o_sum), 32'd108);
`ifdef CSA_ACCUM_THRESHOLD_EN
            check_val("seq3_fire", 32'(o_fire), (t == 0) ? 32'd1 : 32'd0);
`endif
            for (int h = 0; h < 3; h++) cycle(1'b1, ops_rand(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            check_val("seq3_hold", 32'(o_sum), 32'd108);
            cycle(1'b0, ops_rand(), 1'b0, 1'b1, 1'b0);
        end

        // truncation at maximum frame length
        for (int b = 0; b < MAXB; b++) cycle(1'b1, ops_fill(16383), 1'b0, 1'b0, 1'b0);
        check_val("trunc_sum", 32'(o_sum), 32'd2097024);
        check_val("trunc_nbeats", 32'(o_nbeats), 32'd16);
        check_val("trunc_flag", 32'(o_trunc), 32'd1);
        cycle(1'b0, ops_rand(), 1'b0, 1'b1, 1'b0);

        // back-to-back one-beat frames
        for (int b = 0; b < 20; b++) cycle(1'b1, ops_rand(), 1'b1, 1'b1, 1'b0);
        cycle(1'b0, ops_rand(), 1'b0, 1'b1, 1'b0);

        // flush after two of four beats, then a fresh frame
        cycle(1'b1, ops_rand(), 1'b0, 1'b1, 1'b0);
        cycle(1'b1, ops_rand(), 1'b0, 1'b1, 1'b0);
        cycle(1'b1, ops_rand(), 1'b1, 1'b1, 1'b1);
        cycle(1'b1, ops_fill(5), 1'b1, 1'b0, 1'b0);
        check_val("flush_sum", 32'(o_sum), 32'd40);
        check_val("flush_nbeats", 32'(o_nbeats), 32'd1);
        cycle(1'b0, ops_rand(), 1'b0, 1'b1, 1'b0);

        // reset after two of four beats, then a fresh frame
        cycle(1'b1, ops_rand(), 1'b0, 1'b1, 1'b0);
        cycle(1'b1, ops_rand(), 1'b0, 1'b1, 1'b0);
        pulse_reset();
        cycle(1'b1, ops_fill(5), 1'b1, 1'b0, 1'b0);
        check_val("rst_sum", 32'(o_sum), 32'd40);
        check_val("rst_nbeats", 32'(o_nbeats), 32'd1);
        cycle(1'b0, ops_rand(), 1'b0, 1'b1, 1'b0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) thr = SW'($urandom_range(0, 400000));
            cycle(1'($urandom_range(0, 3) != 0), ops_rand(), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
